// File: rtl/lcd_text_writer_pkg.sv
// Shared types and command constants for the HD44780 16x2 text writer.
// Optional feature macro: LCD_SKIP_UNCHANGED_EN (see lcd_text_writer.sv).
package lcd_text_writer_pkg;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_CFG, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2, S_FEND
  } state_e;

  typedef enum logic [2:0] {
    T_PWR, T_IDLE, T_SETUP, T_PULSE, T_GAP, T_WAIT
  } tx_state_e;

  localparam logic [7:0] CMD_FUNC  = 8'h28;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] ADDR_ROW1 = 8'h80;
  localparam logic [7:0] ADDR_ROW2 = 8'hC0;

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Char 0 lives in bits [127:120]; {~idx,3'b000} == (15-idx)*8.
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] idx);
    return row[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Nibble/byte sequencer for the 4-bit LCD bus; owns every timing counter,
// including the power-up delay that runs straight out of reset.
module lcd_nibble_tx
  import lcd_text_writer_pkg::*;
#(
  parameter int PWRUP_CYC      = 2_000_000,
  parameter int INIT_WAIT_CYC  = 500_000,
  parameter int SETUP_CYC      = 4,
  parameter int E_CYC          = 25,
  parameter int NIB_GAP_CYC    = 100,
  parameter int CMD_WAIT_CYC   = 5_000,
  parameter int CLEAR_WAIT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_byte,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  localparam int M0 = (PWRUP_CYC > INIT_WAIT_CYC) ? PWRUP_CYC : INIT_WAIT_CYC;
  localparam int M1 = (M0 > CLEAR_WAIT_CYC) ? M0 : CLEAR_WAIT_CYC;
  localparam int M2 = (M1 > CMD_WAIT_CYC) ? M1 : CMD_WAIT_CYC;
  localparam int M3 = (M2 > NIB_GAP_CYC) ? M2 : NIB_GAP_CYC;
  localparam int M4 = (M3 > E_CYC) ? M3 : E_CYC;
  localparam int MAXP = (M4 > SETUP_CYC) ? M4 : SETUP_CYC;
  localparam int CW = $clog2(MAXP + 1);
  typedef logic [CW-1:0] cnt_t;

  tx_state_e  st_q, st_d;
  cnt_t       cnt_q, cnt_d, wait_lim;
  logic       e_q, e_d, rs_q, rs_d, byte_q, byte_d, long_q, long_d, pend_q, pend_d;
  logic [3:0] d_q, d_d, lo_q, lo_d;

  // long_wait selects the clear wait for a byte and the first-init wait for a nibble
  assign wait_lim = long_q ? (byte_q ? cnt_t'(CLEAR_WAIT_CYC - 1) : cnt_t'(INIT_WAIT_CYC - 1))
                           : cnt_t'(CMD_WAIT_CYC - 1);

  always_comb begin
    st_d = st_q; cnt_d = cnt_q; e_d = e_q; rs_d = rs_q; d_d = d_q;
    byte_d = byte_q; long_d = long_q; pend_d = pend_q; lo_d = lo_q;
    case (st_q)
      T_PWR:
        if (cnt_q == cnt_t'(PWRUP_CYC - 1)) begin st_d = T_IDLE; cnt_d = '0; end
        else cnt_d = cnt_q + cnt_t'(1);
      T_IDLE:
        if (start) begin
          byte_d = is_byte; long_d = long_wait; pend_d = is_byte; rs_d = rs;
          lo_d = data[3:0];
          d_d = is_byte ? data[7:4] : data[3:0];
          st_d = T_SETUP; cnt_d = '0;
        end
      T_SETUP:
        if (cnt_q == cnt_t'(SETUP_CYC - 1)) begin st_d = T_PULSE; e_d = 1'b1; cnt_d = '0; end
        else cnt_d = cnt_q + cnt_t'(1);
      T_PULSE:
        if (cnt_q == cnt_t'(E_CYC - 1)) begin
          e_d = 1'b0; cnt_d = '0;
          st_d = pend_q ? T_GAP : T_WAIT;
        end else cnt_d = cnt_q + cnt_t'(1);
      T_GAP:
        if (cnt_q == cnt_t'(NIB_GAP_CYC - 1)) begin
          d_d = lo_q; pend_d = 1'b0; st_d = T_SETUP; cnt_d = '0;
        end else cnt_d = cnt_q + cnt_t'(1);
      T_WAIT:
        if (cnt_q == wait_lim) begin st_d = T_IDLE; cnt_d = '0; end
        else cnt_d = cnt_q + cnt_t'(1);
      default: st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= T_PWR; cnt_q <= '0; e_q <= 1'b0; rs_q <= 1'b0; d_q <= '0;
      byte_q <= 1'b0; long_q <= 1'b0; pend_q <= 1'b0; lo_q <= '0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; e_q <= e_d; rs_q <= rs_d; d_q <= d_d;
      byte_q <= byte_d; long_q <= long_d; pend_q <= pend_d; lo_q <= lo_d;
    end
  end

  // A start in flight counts as busy so the caller never double-issues.
  assign busy   = (st_q != T_IDLE) | start;
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Top FSM: power-up init, then endless refresh of two 16-char rows from a snapshot.
// Define LCD_SKIP_UNCHANGED_EN to hold in FEND until the row text changes.
module lcd_text_writer
  import lcd_text_writer_pkg::*;
#(
  parameter int PWRUP_CYC      = 2_000_000,
  parameter int INIT_WAIT_CYC  = 500_000,
  parameter int SETUP_CYC      = 4,
  parameter int E_CYC          = 25,
  parameter int NIB_GAP_CYC    = 100,
  parameter int CMD_WAIT_CYC   = 5_000,
  parameter int CLEAR_WAIT_CYC = 200_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] row_A,
  input  logic [127:0] row_B,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [3:0]   LCD_D,
  output logic         init_done,
  output logic         frame_done
);

  state_e       st_q;
  logic [4:0]   idx_q;
  logic [255:0] snap_q;
  logic         start_q, byte_q, rs_q, long_q, init_done_q, frame_done_q;
  logic [7:0]   data_q;
  logic         busy;

  logic         item_vld, item_byte, item_rs, item_long;
  logic [7:0]   item_data;

  // Next item to send in the current state; no item left means advance.
  always_comb begin
    item_vld = 1'b0; item_byte = 1'b1; item_rs = 1'b0; item_long = 1'b0; item_data = '0;
    case (st_q)
      S_INIT: begin
        item_vld = idx_q < 5'd4; item_byte = 1'b0; item_long = idx_q == 5'd0;
        item_data = (idx_q == 5'd3) ? 8'h02 : 8'h03;
      end
      S_CFG: begin
        item_vld = idx_q < 5'd4; item_long = idx_q == 5'd3;
        item_data = cfg_byte(idx_q[1:0]);
      end
      S_ADDR1: begin item_vld = idx_q == 5'd0; item_data = ADDR_ROW1; end
      S_ADDR2: begin item_vld = idx_q == 5'd0; item_data = ADDR_ROW2; end
      S_ROW1: begin
        item_vld = !idx_q[4]; item_rs = 1'b1; item_data = row_char(snap_q[255:128], idx_q[3:0]);
      end
      S_ROW2: begin
        item_vld = !idx_q[4]; item_rs = 1'b1; item_data = row_char(snap_q[127:0], idx_q[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= S_PWRUP; idx_q <= '0; snap_q <= '0; start_q <= 1'b0; byte_q <= 1'b0;
      rs_q <= 1'b0; long_q <= 1'b0; data_q <= '0; init_done_q <= 1'b0; frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (start_q) start_q <= 1'b0;
      else if (!busy) begin
        if (item_vld) begin
          start_q <= 1'b1; byte_q <= item_byte; rs_q <= item_rs;
          long_q <= item_long; data_q <= item_data; idx_q <= idx_q + 5'd1;
        end else begin
          idx_q <= '0;
          case (st_q)
            S_PWRUP: st_q <= S_INIT;
            S_INIT:  st_q <= S_CFG;
            S_CFG:   begin st_q <= S_ADDR1; init_done_q <= 1'b1; snap_q <= {row_A, row_B}; end
            S_ADDR1: st_q <= S_ROW1;
            S_ROW1:  st_q <= S_ADDR2;
            S_ADDR2: st_q <= S_ROW2;
            S_ROW2:  begin st_q <= S_FEND; frame_done_q <= 1'b1; end
            S_FEND: begin
`ifdef LCD_SKIP_UNCHANGED_EN
              if ({row_A, row_B} != snap_q) begin
                st_q <= S_ADDR1; snap_q <= {row_A, row_B};
              end
`else
              st_q <= S_ADDR1; snap_q <= {row_A, row_B};
`endif
            end
            default: st_q <= S_PWRUP;
          endcase
        end
      end
    end
  end

  lcd_nibble_tx #(
    .PWRUP_CYC(PWRUP_CYC), .INIT_WAIT_CYC(INIT_WAIT_CYC), .SETUP_CYC(SETUP_CYC),
    .E_CYC(E_CYC), .NIB_GAP_CYC(NIB_GAP_CYC), .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_tx (
    .clk(clk), .rst(reset), .start(start_q), .is_byte(byte_q), .rs(rs_q), .data(data_q),
    .long_wait(long_q), .busy(busy), .lcd_e(LCD_E), .lcd_rs(LCD_RS), .lcd_d(LCD_D)
  );

  assign LCD_RW     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
